// File: rtl/sad_best_match.sv
`timescale 1ns/1ps
// sad_best_match
// Runs the SAD engine once per candidate block and keeps the minimum SAD
// and the index that produced it. A per-candidate watchdog aborts the
// search if the engine never reports Done.
//
// Ports
//   Clk       in   rising-edge clock
//   Rst       in   asynchronous active-low reset
//   Start     in   begin a search (only honoured while idle)
//   Sad_Done  in   engine Done; its rising edge marks SAD_In valid
//   SAD_In    in   engine SAD result
//   Sad_Go    out  one-cycle launch pulse to the engine
//   Cand_Idx  out  candidate currently being evaluated
//   Best_SAD  out  minimum SAD found so far
//   Best_Idx  out  index of that minimum
//   Busy      out  high whenever the search is not idle
//   Done      out  one-cycle pulse when the search completes
//   Err       out  sticky watchdog-timeout flag, cleared by the next Start
module sad_best_match #(
  parameter int unsigned NUM_CAND = 4,
  parameter int unsigned IDX_W    = 2,
  parameter int unsigned SAD_W    = 32,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Sad_Done,
  input  logic [SAD_W-1:0] SAD_In,
  output logic             Sad_Go,
  output logic [IDX_W-1:0] Cand_Idx,
  output logic [SAD_W-1:0] Best_SAD,
  output logic [IDX_W-1:0] Best_Idx,
  output logic             Busy,
  output logic             Done,
  output logic             Err
);

  localparam int unsigned WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_UPDATE = 3'd3,
    S_FINISH = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cand_q, cand_d;
  logic [SAD_W-1:0] best_sad_q, best_sad_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [SAD_W-1:0] held_q, held_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             err_q, err_d;
  logic             sad_done_dly_q;
  logic             sad_go_q, sad_go_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept_c;

  // Only a fresh rising edge of the engine Done is a valid result.
  assign accept_c = Sad_Done & ~sad_done_dly_q;

  // State register and datapath flops.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q        <= S_IDLE;
      cand_q         <= '0;
      best_sad_q     <= '0;
      best_idx_q     <= '0;
      held_q         <= '0;
      wd_q           <= '0;
      err_q          <= 1'b0;
      sad_done_dly_q <= 1'b0;
      sad_go_q       <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cand_q         <= cand_d;
      best_sad_q     <= best_sad_d;
      best_idx_q     <= best_idx_d;
      held_q         <= held_d;
      wd_q           <= wd_d;
      err_q          <= err_d;
      sad_done_dly_q <= Sad_Done;
      sad_go_q       <= sad_go_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;
    held_d     = held_q;
    wd_d       = wd_q;
    err_d      = err_q;
    sad_go_d   = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          cand_d  = '0;
          err_d   = 1'b0;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (accept_c) begin
          held_d  = SAD_In;
          state_d = S_UPDATE;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_UPDATE: begin
        // Strict less-than so ties keep the earlier candidate.
        if ((cand_q == '0) || (held_q < best_sad_q)) begin
          best_sad_d = held_q;
          best_idx_d = cand_q;
        end
        if (cand_q == IDX_W'(NUM_CAND - 1)) begin
          state_d = S_FINISH;
        end else begin
          cand_d  = cand_q + IDX_W'(1);
          state_d = S_LAUNCH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they appear registered.
    sad_go_d = (state_d == S_LAUNCH);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_FINISH);
  end

  assign Sad_Go   = sad_go_q;
  assign Cand_Idx = cand_q;
  assign Best_SAD = best_sad_q;
  assign Best_Idx = best_idx_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Err      = err_q;

endmodule

// File: tb/tb_sad_best_match.sv
`timescale 1ns/1ps
// Self-checking bench for sad_best_match: a cycle-level SAD engine
// responder plus a reference model of the expected search outcome.
module tb_sad_best_match;

  localparam int unsigned NC = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned SW = 32;
  localparam int unsigned TO = 16;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          Start, Sad_Done;
  logic [SW-1:0] SAD_In;
  logic          Sad_Go, Busy, Done, Err;
  logic [IW-1:0] Cand_Idx, Best_Idx;
  logic [SW-1:0] Best_SAD;

  logic          Start1, Sad_Done1;
  logic [SW-1:0] SAD_In1;
  logic          Sad_Go1, Busy1, Done1, Err1;
  logic [0:0]    Cand_Idx1, Best_Idx1;
  logic [SW-1:0] Best_SAD1;

  always #5 Clk = ~Clk;

  sad_best_match #(.NUM_CAND(NC), .IDX_W(IW), .SAD_W(SW), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Sad_Done(Sad_Done), .SAD_In(SAD_In),
    .Sad_Go(Sad_Go), .Cand_Idx(Cand_Idx), .Best_SAD(Best_SAD), .Best_Idx(Best_Idx),
    .Busy(Busy), .Done(Done), .Err(Err)
  );

  sad_best_match #(.NUM_CAND(1), .IDX_W(1), .SAD_W(SW), .TIMEOUT(TO)) dut1 (
    .Clk(Clk), .Rst(Rst), .Start(Start1), .Sad_Done(Sad_Done1), .SAD_In(SAD_In1),
    .Sad_Go(Sad_Go1), .Cand_Idx(Cand_Idx1), .Best_SAD(Best_SAD1), .Best_Idx(Best_Idx1),
    .Busy(Busy1), .Done(Done1), .Err(Err1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference state and per-search configuration.
  logic [SW-1:0] prev_best;
  int            prev_idx;
  logic [SW-1:0] sad_v [NC];
  int            lat_v [NC];
  int            hang_at;
  bit            mid_start;

  // One full search on the NUM_CAND=4 instance against the reference model.
  task automatic run_search();
    int cyc, go_cnt, done_at, done_cyc, exp_cyc, ncomp;
    bit injected;
    logic [SW-1:0] eb;
    int ei;

    // Model: best = minimum over completed candidates, earliest index on ties.
    ncomp = (hang_at < 0) ? NC : hang_at;
    eb = prev_best;
    ei = prev_idx;
    if (ncomp > 0) begin
      eb = sad_v[0];
      for (int i = 1; i < ncomp; i++) if (sad_v[i] < eb) eb = sad_v[i];
      ei = -1;
      for (int i = 0; i < ncomp; i++) if (ei < 0 && sad_v[i] == eb) ei = i;
    end
    exp_cyc = 1;
    for (int i = 0; i < ncomp; i++) exp_cyc += lat_v[i] + 2;
    if (hang_at >= 0) exp_cyc += 1 + int'(TO);

    Start    = 1'b1;
    cyc      = 0;
    go_cnt   = 0;
    done_at  = -1;
    done_cyc = -1;
    injected = 1'b0;
    while (cyc < 400 && done_cyc < 0) begin
      @(posedge Clk); #1;
      cyc++;
      Start = 1'b0;
      if (mid_start && go_cnt == 2 && !injected) begin
        Start    = 1'b1;
        injected = 1'b1;
      end
      Sad_Done = 1'b0;
      SAD_In   = $urandom;
      if (Sad_Go) begin
        if (go_cnt == 0) begin
          check_eq("best_hold_at_launch", 64'(Best_SAD), 64'(prev_best));
          check_eq("err_cleared_by_start", 64'(Err), 64'd0);
        end
        check_eq("cand_idx_at_go", 64'(Cand_Idx), 64'(go_cnt));
        if (go_cnt < int'(NC) && go_cnt != hang_at) done_at = cyc + lat_v[go_cnt];
        else done_at = -1;
        go_cnt++;
      end
      if (cyc == done_at && go_cnt >= 1 && go_cnt <= int'(NC)) begin
        Sad_Done = 1'b1;
        SAD_In   = sad_v[go_cnt-1];
      end
      if (Done) done_cyc = cyc;
    end
    Start    = 1'b0;
    Sad_Done = 1'b0;

    if (done_cyc < 0) begin
      check_eq("done_never_seen", 64'd0, 64'd1);
    end else begin
      check_eq("done_latency", 64'(done_cyc), 64'(exp_cyc));
      check_eq("best_sad", 64'(Best_SAD), 64'(eb));
      check_eq("best_idx", 64'(Best_Idx), 64'(ei));
      check_eq("err", 64'(Err), (hang_at >= 0) ? 64'd1 : 64'd0);
      check_eq("cand_idx_final", 64'(Cand_Idx), 64'((hang_at >= 0) ? hang_at : int'(NC) - 1));
      check_eq("go_count", 64'(go_cnt), 64'((hang_at >= 0) ? hang_at + 1 : int'(NC)));
      check_eq("busy_in_finish", 64'(Busy), 64'd1);
      @(posedge Clk); #1;
      check_eq("done_one_cycle", 64'(Done), 64'd0);
      check_eq("idle_after_done", 64'(Busy), 64'd0);
      check_eq("no_go_after_done", 64'(Sad_Go), 64'd0);
    end
    prev_best = eb;
    prev_idx  = ei;
  endtask

  task automatic set_cfg(input logic [SW-1:0] s0, s1, s2, s3, input int lat, input int hang);
    sad_v[0] = s0; sad_v[1] = s1; sad_v[2] = s2; sad_v[3] = s3;
    for (int i = 0; i < int'(NC); i++) lat_v[i] = lat;
    hang_at   = hang;
    mid_start = 1'b0;
  endtask

  initial begin
    int k;
    Rst = 1'b0; Start = 1'b0; Sad_Done = 1'b0; SAD_In = '0;
    Start1 = 1'b0; Sad_Done1 = 1'b0; SAD_In1 = '0;
    prev_best = '0; prev_idx = 0;
    #1;
    check_eq("rst_busy", 64'(Busy), 64'd0);
    check_eq("rst_go", 64'(Sad_Go), 64'd0);
    check_eq("rst_best", 64'(Best_SAD), 64'd0);
    check_eq("rst_err", 64'(Err), 64'd0);
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b1;
    @(posedge Clk); #1;

    // Basic search with a tie: earliest index wins.
    set_cfg(32'd9, 32'd4, 32'd7, 32'd4, 5, -1);
    run_search();
    // Same search with Start pulsed during candidate 1.
    set_cfg(32'd9, 32'd4, 32'd7, 32'd4, 5, -1);
    mid_start = 1'b1;
    run_search();
    // All-ones SADs, then strictly decreasing SADs.
    set_cfg(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, -1);
    run_search();
    set_cfg(32'd5, 32'd3, 32'd2, 32'd1, 1, -1);
    run_search();
    // Engine hangs on candidate 2, then a clean search clears Err.
    set_cfg(32'd8, 32'd3, 32'd0, 32'd0, 4, 2);
    run_search();
    set_cfg(32'd20, 32'd30, 32'd10, 32'd10, 2, -1);
    run_search();
    // Hang on candidate 0: previous best must survive.
    set_cfg(32'd1, 32'd1, 32'd1, 32'd1, 2, 0);
    run_search();

    // Randomized searches.
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < int'(NC); i++) begin
        sad_v[i] = ($urandom_range(0, 2) == 0) ? SW'($urandom_range(0, 3)) : SW'($urandom);
        lat_v[i] = $urandom_range(1, 10);
      end
      hang_at   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NC - 1)) : -1;
      mid_start = ($urandom_range(0, 3) == 0);
      run_search();
    end

    // Asynchronous reset mid-WAIT.
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    k = 0;
    while (!Sad_Go && k < 10) begin
      @(posedge Clk); #1;
      k++;
    end
    check_eq("go_before_reset", 64'(Sad_Go), 64'd1);
    repeat (2) @(posedge Clk);
    #3 Rst = 1'b0;
    #1;
    check_eq("arst_busy", 64'(Busy), 64'd0);
    check_eq("arst_go", 64'(Sad_Go), 64'd0);
    check_eq("arst_best_sad", 64'(Best_SAD), 64'd0);
    check_eq("arst_best_idx", 64'(Best_Idx), 64'd0);
    check_eq("arst_err", 64'(Err), 64'd0);
    check_eq("arst_cand", 64'(Cand_Idx), 64'd0);
    check_eq("arst_done", 64'(Done), 64'd0);
    @(posedge Clk); #1;
    Rst = 1'b1;
    prev_best = '0;
    prev_idx  = 0;
    @(posedge Clk); #1;
    set_cfg(32'd77, 32'd12, 32'd90, 32'd13, 3, -1);
    run_search();

    // Single-candidate instance: a stale high Done must not be accepted.
    Sad_Done1 = 1'b1;
    SAD_In1   = 32'd99;
    repeat (3) @(posedge Clk);
    #1 Start1 = 1'b1;
    @(posedge Clk); #1;
    Start1 = 1'b0;
    check_eq("nc1_go", 64'(Sad_Go1), 64'd1);
    check_eq("nc1_busy", 64'(Busy1), 64'd1);
    repeat (3) @(posedge Clk);
    #1 Sad_Done1 = 1'b0;
    @(posedge Clk); #1;
    Sad_Done1 = 1'b1;
    SAD_In1   = 32'd6;
    @(posedge Clk); #1;
    Sad_Done1 = 1'b0;
    SAD_In1   = 32'd55;
    k = 0;
    while (!Done1 && k < 10) begin
      @(posedge Clk); #1;
      k++;
    end
    check_eq("nc1_done", 64'(Done1), 64'd1);
    check_eq("nc1_best_sad", 64'(Best_SAD1), 64'd6);
    check_eq("nc1_best_idx", 64'(Best_Idx1), 64'd0);
    check_eq("nc1_cand", 64'(Cand_Idx1), 64'd0);
    check_eq("nc1_err", 64'(Err1), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sad_best_match.md
Name: sad_best_match

Overview:
- Sequences the SAD engine over NUM_CAND candidate blocks and tracks the best (minimum) SAD and its candidate index.
- Sits directly downstream of the SAD datapath/controller: it pulses the SAD Go, consumes SAD_Out and Done, and reports a motion-search result.
- Cand_Idx is exported so address logic can offset the B-operand base per candidate.
- Includes a per-candidate watchdog so a hung SAD engine cannot stall the search.

Parameters:
NUM_CAND, 4, number of candidates searched per Start (>=1)
IDX_W, 2, width of candidate index (ceil(log2(NUM_CAND)), min 1)
SAD_W, 32, width of SAD value
TIMEOUT, 1024, max cycles in WAIT per candidate before abort (>=2)

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  asynchronous, active-low reset
Start  in  1  begin search; sampled in IDLE only
Sad_Done  in  1  Done from SAD engine; rising edge marks result valid
SAD_In  in  SAD_W  SAD_Out from SAD engine
Sad_Go  out  1  one-cycle launch pulse to SAD engine
Cand_Idx  out  IDX_W  candidate currently being evaluated
Best_SAD  out  SAD_W  minimum SAD found
Best_Idx  out  IDX_W  index of minimum
Busy  out  1  high in every state except IDLE
Done  out  1  one-cycle pulse on search completion
Err  out  1  sticky timeout flag, cleared by next accepted Start

Behaviour:
- One clock; reset asynchronous, active-low. Rst=0 forces state IDLE and all outputs/registers to 0 immediately (Sad_Go, Cand_Idx, Best_SAD, Best_Idx, Busy, Done, Err, watchdog, Done_d). This applies mid-search too; no pending result survives.
- States: IDLE, LAUNCH, WAIT, UPDATE, FINISH.
- IDLE:
  - Start=1 at an edge: clear Cand_Idx and Err, enter LAUNCH.
  - Best_SAD and Best_Idx hold their previous result until the first UPDATE of the new search.
- LAUNCH:
  - Sad_Go=1 for exactly this cycle; watchdog cleared; next state WAIT.
- WAIT:
  - Done_d is Sad_Done registered every cycle.
  - Accept when Sad_Done=1 and Done_d=0 (rising edge). A level-high Done left over from a previous run is never accepted.
  - On accept: capture SAD_In into a holding register, go to UPDATE.
  - Otherwise increment the watchdog. When it reaches TIMEOUT-1 without accept: set Err=1, go to FINISH.
- UPDATE, one cycle:
  - If Cand_Idx==0, or held SAD < Best_SAD (unsigned, strict): Best_SAD <= held, Best_Idx <= Cand_Idx.
  - Ties keep the earlier index.
  - If Cand_Idx==NUM_CAND-1, go to FINISH; else Cand_Idx++ and go to LAUNCH.
- FINISH:
  - Done=1 for exactly this cycle; next state IDLE.
  - Cand_Idx holds the last evaluated index.
- Latency:
  - Start edge t gives Sad_Go high in cycle t+1.
  - Per candidate: 1 (LAUNCH) + L (Go to Done rise, measured from LAUNCH) + 1 (UPDATE).
  - Done is high one cycle after the final UPDATE.
  - Minimum total cycles from Start to Done = NUM_CAND*(L+2)+1.
- Start while Busy is ignored: no restart, no effect on the counter.
- Sad_Done rising outside WAIT is ignored, but Done_d still tracks it.
- On timeout, Best_SAD/Best_Idx reflect only the candidates completed before the abort. If none completed, they keep the previous-search values.
- Width rules: comparison is unsigned over SAD_W bits. No arithmetic is done on SAD values. Cand_Idx never wraps past NUM_CAND-1.
- NUM_CAND=1 path: LAUNCH, WAIT, UPDATE, FINISH; Best_Idx=0.

Test Plan:
1. NUM_CAND=4; SAD model returns 9,4,7,4 with L=5 -> exactly 4 Sad_Go pulses; Done pulse at cycle 4*7+1=29 after Start; Best_SAD=4, Best_Idx=1 (tie keeps 1, not 3); Err=0.
2. All four SADs = 0xFFFFFFFF -> Best_SAD=0xFFFFFFFF, Best_Idx=0; SADs 5,3,2,1 -> Best_SAD=1, Best_Idx=3.
3. SAD model never raises Done for candidate 2, TIMEOUT=16 -> Err=1 and Done pulse 16 cycles after entering WAIT; Best reflects candidates 0-1 only. Next Start clears Err.
4. Sad_Done held high before Start, then SAD gives 6 -> stale level is not accepted; only the fresh rising edge updates; Best_SAD=6 when NUM_CAND=1.
5. Start pulsed again during candidate 1 -> ignored; Sad_Go count stays 4; result is unchanged from scenario 1.
6. Rst=0 asserted asynchronously mid-WAIT -> Busy, Sad_Go, Best_SAD, Best_Idx, Err all 0 immediately, state IDLE. A later Start runs a clean full search.
